// File: rtl/bj_pkg.sv
// Shared types and card arithmetic for the blackjack hand controller.
package bj_pkg;

  typedef enum logic [2:0] {
    IDLE, DEAL, PLAYER, P_DRAW, DEALER, D_DRAW, DONE
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_PLAYER = 2'd1,
    RES_DEALER = 2'd2,
    RES_PUSH   = 2'd3
  } result_t;

  localparam logic [3:0] ACE      = 4'd1;
  localparam logic [3:0] FACE_MIN = 4'd11;
  localparam logic [4:0] BJ       = 5'd21;

  function automatic logic [4:0] card_value(input logic [3:0] rank);
    if (rank >= FACE_MIN) return 5'd10;
    return {1'b0, rank};
  endfunction

  // One ace counts as 11 only while that keeps the hand at or below 21.
  function automatic logic [4:0] best_score(input logic [4:0] hard, input logic ace);
    if (ace && hard <= 5'd11) return hard + 5'd10;
    return hard;
  endfunction

endpackage

// File: rtl/bj_hand_acc.sv
// Single-hand accumulator: hard sum with aces as 1, plus a seen-an-ace flag.
module bj_hand_acc
  import bj_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] number,
  output logic [4:0] hard_sum,
  output logic       ace,
  output logic [4:0] score,
  output logic       bust
);

  // Worst case is 21 plus a ten-valued card, so 5 bits never wrap.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hard_sum <= 5'd0;
      ace      <= 1'b0;
    end else if (load) begin
      hard_sum <= hard_sum + card_value(number);
      ace      <= ace | (number == ACE);
    end
  end

  always_comb begin
    score = best_score(hard_sum, ace);
    bust  = (hard_sum > BJ);
  end

endmodule

// File: rtl/bj_hand_ctrl.sv
// Blackjack round sequencer: deals, runs player and dealer turns, scores the round.
//   state  | meaning
//   IDLE   | after reset, waiting for start
//   DEAL   | fetching P, D, P, D
//   PLAYER | waiting for hit or stand
//   P_DRAW | fetching one player card
//   DEALER | deciding whether the dealer draws
//   D_DRAW | fetching one dealer card
//   DONE   | round over, outcome held
module bj_hand_ctrl
  import bj_pkg::*;
#(
  parameter int unsigned DEALER_STAND = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       hit,
  input  logic       stand,
  input  logic [3:0] number,
  input  logic [1:0] suits,
  input  logic       empty,
  output logic       pip,
  output logic [4:0] player_score,
  output logic [4:0] dealer_score,
  output logic [1:0] last_suit,
  output logic [1:0] result,
  output logic       abort,
  output logic       done
);

  localparam logic [4:0] STAND_SCORE = 5'(DEALER_STAND);

  state_t     state, state_nx;
  logic       phase;
  logic [1:0] deal_cnt;
  result_t    result_q, dealer_result;
  logic       abort_q;
  logic [1:0] suit_q;

  logic [4:0] p_hard, d_hard, sel_hard, hard_nx, score_nx;
  logic       p_ace, d_ace, p_bust, d_bust, ace_nx;
  logic       fetch, want_pip, starved, capture, card_ok, clear_hands;
  logic       to_player, p_load, d_load, dealer_draws;

  bj_hand_acc u_player (
    .clk(clk), .rst(rst), .clear(clear_hands), .load(p_load), .number(number),
    .hard_sum(p_hard), .ace(p_ace), .score(player_score), .bust(p_bust)
  );

  bj_hand_acc u_dealer (
    .clk(clk), .rst(rst), .clear(clear_hands), .load(d_load), .number(number),
    .hard_sum(d_hard), .ace(d_ace), .score(dealer_score), .bust(d_bust)
  );

  // phase=0: request slot, phase=1: capture slot of the same card.
  always_comb begin
    fetch       = (state == DEAL) || (state == P_DRAW) || (state == D_DRAW);
    want_pip    = fetch && !phase;
    starved     = want_pip && empty;
    capture     = fetch && phase;
    card_ok     = (number != 4'd0);
    clear_hands = start && ((state == IDLE) || (state == DONE));
    to_player   = (state == P_DRAW) || ((state == DEAL) && !deal_cnt[0]);
    p_load      = capture && card_ok && to_player;
    d_load      = capture && card_ok && !to_player;
    // Look ahead at the hand including the card being captured this cycle.
    sel_hard    = to_player ? p_hard : d_hard;
    hard_nx     = sel_hard + card_value(number);
    ace_nx      = (to_player ? p_ace : d_ace) | (number == ACE);
    score_nx    = best_score(hard_nx, ace_nx);
    dealer_draws = (dealer_score < STAND_SCORE);
    if (p_bust)                                      dealer_result = RES_DEALER;
    else if (d_bust || player_score > dealer_score)  dealer_result = RES_PLAYER;
    else if (dealer_score > player_score)            dealer_result = RES_DEALER;
    else                                             dealer_result = RES_PUSH;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = DEAL;
      DEAL: begin
        if (starved || (capture && !card_ok))  state_nx = DONE;
        else if (capture && deal_cnt == 2'd3)  state_nx = PLAYER;
      end
      PLAYER: begin
        if (hit)        state_nx = P_DRAW;
        else if (stand) state_nx = DEALER;
      end
      P_DRAW: begin
        if (starved || (capture && !card_ok)) state_nx = DONE;
        else if (capture) begin
          if (hard_nx > BJ)       state_nx = DONE;
          else if (score_nx == BJ) state_nx = DEALER;
          else                     state_nx = PLAYER;
        end
      end
      DEALER: state_nx = dealer_draws ? D_DRAW : DONE;
      D_DRAW: begin
        if (starved || (capture && !card_ok)) state_nx = DONE;
        else if (capture)                     state_nx = DEALER;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pip  = want_pip && !empty;
    done = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst || clear_hands) begin
      phase    <= 1'b0;
      deal_cnt <= 2'd0;
      result_q <= RES_NONE;
      abort_q  <= 1'b0;
      suit_q   <= 2'd0;
    end else begin
      if (pip)          phase <= 1'b1;
      else if (capture) phase <= 1'b0;
      if (capture && card_ok) suit_q <= suits;
      if (capture && card_ok && state == DEAL) deal_cnt <= deal_cnt + 2'd1;
      if (starved || (capture && !card_ok)) abort_q <= 1'b1;
      if (state == P_DRAW && capture && card_ok && hard_nx > BJ) result_q <= RES_DEALER;
      if (state == DEALER && !dealer_draws) result_q <= dealer_result;
    end
  end

  assign result    = result_q;
  assign abort     = abort_q;
  assign last_suit = suit_q;

endmodule

// File: tb/tb_bj_hand_ctrl.sv
// Randomized round bench: the bench plays the upstream deck and the player, a rule-level model predicts each round.
module tb_bj_hand_ctrl;

  logic       clk, rst, start, hit, stand, empty;
  logic [3:0] number;
  logic [1:0] suits;
  logic       pip, abort, done;
  logic [4:0] player_score, dealer_score;
  logic [1:0] last_suit, result;

  bj_hand_ctrl #(.DEALER_STAND(17)) dut (
    .clk(clk), .rst(rst), .start(start), .hit(hit), .stand(stand),
    .number(number), .suits(suits), .empty(empty), .pip(pip),
    .player_score(player_score), .dealer_score(dealer_score),
    .last_suit(last_suit), .result(result), .abort(abort), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int p;
    int d;
    int res;
    int abrt;
    int suit;
    int hits;
  } exp_t;

  exp_t sb[$];
  int   deck_n[16];
  int   deck_s[16];
  int   deck_len;
  int   errors = 0;
  int   checks = 0;
  logic idle_chk = 1'b0;
  logic tmo = 1'b0;
  logic fin = 1'b0;

  // ---------------- reference model: rules of the game, card by card ----------------
  function automatic int val(int r);
    return (r >= 11) ? 10 : r;
  endfunction

  function automatic int best(int h, bit a);
    return (a && h + 10 <= 21) ? h + 10 : h;
  endfunction

  function automatic bit grab(inout int i, output int r, output int s);
    r = 0; s = 0;
    if (i >= deck_len || deck_n[i] == 0) return 1'b0;
    r = deck_n[i]; s = deck_s[i]; i++;
    return 1'b1;
  endfunction

  function automatic exp_t model(int thr);
    exp_t e;
    int i, r, s, ph, dh;
    bit pa, da, ok, pend, pbust;
    e = '{default: 0};
    i = 0; ph = 0; dh = 0; pa = 0; da = 0; ok = 1; pend = 0; pbust = 0;
    for (int k = 0; k < 4 && ok; k++) begin
      ok = grab(i, r, s);
      if (ok) begin
        if (k % 2 == 0) begin ph += val(r); pa |= (r == 1); end
        else            begin dh += val(r); da |= (r == 1); end
        e.suit = s;
      end
    end
    while (ok && !pend && best(ph, pa) < thr) begin
      e.hits++;
      ok = grab(i, r, s);
      if (ok) begin
        ph += val(r); pa |= (r == 1); e.suit = s;
        if (ph > 21) begin pbust = 1; pend = 1; end
        else if (best(ph, pa) == 21) pend = 1;
      end
    end
    while (ok && !pbust && best(dh, da) < 17) begin
      ok = grab(i, r, s);
      if (ok) begin dh += val(r); da |= (r == 1); e.suit = s; end
    end
    e.p = best(ph, pa);
    e.d = best(dh, da);
    if (!ok)                       e.abrt = 1;
    else if (pbust)                e.res = 2;
    else if (dh > 21 || e.p > e.d) e.res = 1;
    else if (e.d > e.p)            e.res = 2;
    else                           e.res = 3;
    return e;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic pip_q = 1'b0;
  logic done_q = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (pip) begin
      checks++;
      if (pip_q || empty) begin
        errors++;
        $display("FAIL pip_rule: prev_pip=%0d empty=%0d, both must be 0 when pip=1", pip_q, empty);
      end
    end
    pip_q = pip;
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: done rose with no round outstanding");
      end else begin
        e = sb.pop_front();
        chk("player_score", int'(player_score), e.p);
        chk("dealer_score", int'(dealer_score), e.d);
        chk("result",       int'(result),       e.res);
        chk("abort",        int'(abort),        e.abrt);
        chk("last_suit",    int'(last_suit),    e.suit);
      end
    end
    done_q = done;
    if (idle_chk) begin
      chk("idle_pip",    int'(pip), 0);
      chk("idle_pscore", int'(player_score), 0);
      chk("idle_dscore", int'(dealer_score), 0);
      chk("idle_suit",   int'(last_suit), 0);
      chk("idle_result", int'(result), 0);
      chk("idle_abort",  int'(abort), 0);
      chk("idle_done",   int'(done), 0);
    end
    if (tmo) chk("round_timeout_done", int'(done), 1);
    if (fin) chk("sb_leftover", sb.size(), 0);
  end

  // ---------------- stimulus ----------------
  task automatic set_deck(input int n, input int c0, input int c1, input int c2,
                          input int c3, input int c4, input int c5);
    int c[6];
    c = '{c0, c1, c2, c3, c4, c5};
    deck_len = n;
    for (int k = 0; k < 16; k++) begin
      deck_n[k] = (k < 6) ? c[k] : 0;
      deck_s[k] = $urandom_range(0, 3);
    end
  endtask

  task automatic run_round(input int thr, input bit both);
    exp_t e;
    int idx, draws;
    bit ps, seen;
    e = model(thr);
    sb.push_back(e);
    idx = 0; draws = 0; seen = 0;
    hit = 0; stand = 0; number = 0;
    empty = (deck_len == 0);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    for (int c = 0; c < 400 && !seen; c++) begin
      @(negedge clk);
      ps = pip; seen = done;
      if (!seen) begin
        @(posedge clk); #1;
        if (ps) begin
          number = 4'(deck_n[idx]); suits = 2'(deck_s[idx]);
          idx++; draws++;
        end else begin
          number = 4'd0; suits = 2'($urandom_range(0, 3));
        end
        empty = (idx >= deck_len);
        hit   = (draws >= 4) && (draws - 4 < e.hits);
        stand = !hit || both;
      end
    end
    if (!seen) begin
      @(posedge clk); #1 tmo = 1;
      @(posedge clk); #1 tmo = 0;
    end
    hit = 0; stand = 0; number = 0;
    repeat (2) @(posedge clk);
  endtask

  task automatic mid_deal_reset();
    int idx;
    bit ps;
    set_deck(6, 10, 7, 6, 9, 5, 4);
    idx = 0; empty = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); ps = pip;
      @(posedge clk); #1;
      if (ps) begin number = 4'(deck_n[idx]); suits = 2'(deck_s[idx]); idx++; end
      else number = 4'd0;
    end
    rst = 1;
    @(posedge clk); #1 rst = 0; idle_chk = 1;
    @(posedge clk); #1 idle_chk = 0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int n;
    rst = 1; start = 0; hit = 0; stand = 0; number = 0; suits = 0; empty = 0;
    deck_len = 0;
    repeat (3) @(posedge clk);
    #1 idle_chk = 1;
    @(posedge clk); #1 idle_chk = 0; rst = 0;
    // start held together with reset must be ignored
    @(posedge clk); #1 rst = 1; start = 1;
    @(posedge clk); #1 rst = 0; start = 0; idle_chk = 1;
    @(posedge clk); #1 idle_chk = 0;

    set_deck(5, 12, 6, 1, 8, 9, 0);  run_round(17, 0);  // natural 21, dealer busts
    set_deck(5, 10, 7, 6, 9, 12, 0); run_round(17, 1);  // player bust
    set_deck(6, 1, 10, 6, 9, 9, 5);  run_round(18, 0);  // soft 17 demoted to 16
    set_deck(4, 10, 1, 8, 6, 0, 0);  run_round(17, 0);  // dealer soft 17, player 18
    set_deck(4, 10, 1, 7, 6, 0, 0);  run_round(17, 0);  // push at 17
    set_deck(4, 10, 7, 6, 9, 0, 0);  run_round(20, 0);  // deck empty at first hit
    set_deck(5, 10, 7, 0, 9, 5, 0);  run_round(17, 0);  // no-card rank during deal
    set_deck(0, 0, 0, 0, 0, 0, 0);   run_round(17, 0);  // empty before first pip
    mid_deal_reset();

    for (int r = 0; r < 60; r++) begin
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : $urandom_range(7, 16);
      deck_len = n;
      for (int k = 0; k < 16; k++) begin
        deck_n[k] = ($urandom_range(0, 29) == 0) ? 0 : $urandom_range(1, 13);
        deck_s[k] = $urandom_range(0, 3);
      end
      run_round($urandom_range(12, 21), 1'($urandom_range(0, 1)));
    end

    mid_deal_reset();
    set_deck(5, 12, 6, 1, 8, 9, 0);  run_round(17, 0);

    @(posedge clk); #1 fin = 1;
    @(posedge clk); #1 fin = 0;
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bj_hand_ctrl.md
BJ_HAND_CTRL -- requirements
Module: bj_hand_ctrl

Interface
REQ-001 SHALL have parameter DEALER_STAND, default 17, the dealer score at or above which the dealer stops drawing.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1, begin a new round; honoured only in IDLE or DONE.
REQ-005 SHALL have port hit, input, 1, player requests a card; sampled only in PLAYER.
REQ-006 SHALL have port stand, input, 1, player ends the turn; sampled only in PLAYER.
REQ-007 SHALL have port number, input, 4, card rank from the upstream dealer: 1=ace, 2..13, 0=no card.
REQ-008 SHALL have port suits, input, 2, card suit; carried to last_suit and otherwise unused.
REQ-009 SHALL have port empty, input, 1, high when the upstream deck is exhausted.
REQ-010 SHALL have port pip, output, 1, one-cycle card request to the upstream dealer.
REQ-011 SHALL have port player_score, output, 5, best player score.
REQ-012 SHALL have port dealer_score, output, 5, best dealer score.
REQ-013 SHALL have port last_suit, output, 2, suit of the most recently captured card.
REQ-014 SHALL have port result, output, 2, round outcome: 0 none, 1 player win, 2 dealer win, 3 push.
REQ-015 SHALL have port abort, output, 1, round ended because no card was available.
REQ-016 SHALL have port done, output, 1, high while in DONE.

Function
REQ-017 FSM states SHALL be IDLE, DEAL, PLAYER, P_DRAW, DEALER, D_DRAW, DONE.
REQ-018 Card fetch SHALL be: pip high for one cycle in cycle t, card captured from number/suits in cycle t+1; one card per two cycles, and pip never high on consecutive cycles.
REQ-019 Card value SHALL be: ace=1 hard; 2..10 face value; 11..13 value 10.
REQ-020 Each hand SHALL keep hard_sum (5 bits, aces as 1) and an ace flag; score = hard_sum+10 if the ace flag is set and hard_sum<=11, else hard_sum.
REQ-021 A hand SHALL be bust when hard_sum>21; hard_sum never exceeds 31, so it needs no saturation.
REQ-022 start in IDLE or DONE SHALL clear both hands, result, abort and last_suit, then enter DEAL.
REQ-023 DEAL SHALL fetch four cards in the order player, dealer, player, dealer (8 cycles), then enter PLAYER.
REQ-024 In PLAYER, hit SHALL go to P_DRAW; stand SHALL go to DEALER; if both are high, hit wins.
REQ-025 P_DRAW SHALL fetch one card and then go as follows:
- to DONE with result=2 if the player is bust;
- to DEALER if player_score==21;
- otherwise back to PLAYER.
REQ-026 DEALER SHALL go to D_DRAW while dealer_score<DEALER_STAND, otherwise to DONE; the dealer stands on soft 17.
REQ-027 On entering DONE after the dealer turn, result SHALL be:
- 1 if the dealer is bust or player_score>dealer_score;
- 2 if dealer_score>player_score;
- 3 if the scores are equal.
REQ-028 If empty is high when a pip would issue, or the captured number==0, the block SHALL go to DONE with abort=1 and result=0, with no pip.
REQ-029 result, abort and both scores SHALL hold in DONE until the next start or rst.

Reset
REQ-030 rst SHALL force the following, overriding every other input including start, and SHALL apply mid-round with any pending card discarded:
- state IDLE;
- pip=0, player_score=0, dealer_score=0, last_suit=0;
- result=0, abort=0, done=0.

Structure
REQ-031 Package bj_pkg SHALL hold the state enum, the result codes, the ranks ACE=1 and FACE_MIN=11, and the constant BJ=21.
REQ-032 One sub-module bj_hand_acc (clear, load, number in; hard_sum, ace, score, bust out) SHALL be instanced twice, once for the player and once for the dealer.

Verification
REQ-033 Natural 21: ranks 12,6,1,8, player stands, next rank 9 -> player 21, dealer 14 then 23 (bust), result=1.
REQ-034 Player bust: ranks 10,7,6,9, hit, rank 12 -> player 26, result=2 in the cycle after capture, dealer draws none.
REQ-035 Soft demotion: ranks 1,10,6,9, hit, rank 9 -> player score 17 then hit 9 gives 16 hard (ace demoted), not bust.
REQ-036 Push and soft 17: ranks 10,1,8,6, stand -> dealer holds soft 17 with no draw; with player 18 the result is 1, with player 17 (ranks 10,1,7,6) the result is 3.
REQ-037 Exhaustion: empty=1 at the first hit -> no pip, abort=1, result=0, done=1; rst mid-DEAL -> all outputs 0 on the next cycle.
